// File: rtl/if_stage_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NopInstrDefault = 32'h0000_0000;
    localparam int unsigned PcIncr          = 4;

endpackage

// File: rtl/if_stage_fetch_unit_if_id_pipe_reg.sv
// IF/ID pipeline register: flush beats load, load beats bubble, otherwise hold.
module if_id_pipe_reg #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end else if (bubble_i) begin
            // Bubble keeps the last PC; only instruction and valid are cleared.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage_fetch_unit.sv
// Instruction fetch stage with IF/ID register and one-entry hold buffer.
// Optional FETCH_STATS_EN adds delivered-instruction and stall-cycle counters.
module if_stage_fetch_unit
    import if_stage_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NopInstrDefault)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] if_id_pc_o,
    output logic [DATA_W-1:0] if_id_instr_o,
    output logic              if_id_valid_o,
    output logic              fetch_busy_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched_o,
    output logic [31:0]       stat_stall_o
`endif
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_pc_q;
    // Only the instruction is buffered: in HOLD, pc_q already equals its PC+4.
    logic [DATA_W-1:0] hold_instr_q;

    logic [ADDR_W-1:0] pc_inc;
    logic              done;
    logic              ifid_load;
    logic              ifid_bubble;
    logic [ADDR_W-1:0] ifid_pc;
    logic [DATA_W-1:0] ifid_instr;

    assign pc_inc       = pc_q + ADDR_W'(PcIncr);
    assign imem_req_o   = rst_n & (state_q != StHold);
    assign imem_addr_o  = pc_q;
    assign done         = imem_req_o & imem_ready_i;
    assign fetch_busy_o = imem_req_o & ~imem_ready_i;

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_pc     = pc_inc;
        ifid_instr  = imem_rdata_i;
        unique case (state_q)
            StFetch: begin
                if (!freeze_i) begin
                    ifid_load   = done;
                    ifid_bubble = ~done;
                end
            end
            StHold: begin
                ifid_load  = ~freeze_i;
                ifid_pc    = pc_q;
                ifid_instr = hold_instr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (branch_taken_i) begin
                        if (done) begin
                            pc_q <= branch_addr_i;
                        end else begin
                            // Address must stay put until memory accepts it.
                            pend_pc_q <= branch_addr_i;
                            state_q   <= StDrain;
                        end
                    end else if (done) begin
                        pc_q <= pc_inc;
                        if (freeze_i) begin
                            hold_instr_q <= imem_rdata_i;
                            state_q      <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (branch_taken_i) begin
                        pc_q    <= branch_addr_i;
                        state_q <= StFetch;
                    end else if (!freeze_i) begin
                        state_q <= StFetch;
                    end
                end
                StDrain: begin
                    if (done) begin
                        pc_q    <= branch_taken_i ? branch_addr_i : pend_pc_q;
                        state_q <= StFetch;
                    end else if (branch_taken_i) begin
                        pend_pc_q <= branch_addr_i;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    if_id_pipe_reg #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_pipe_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (branch_taken_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc_i     (ifid_pc),
        .instr_i  (ifid_instr),
        .pc_o     (if_id_pc_o),
        .instr_o  (if_id_instr_o),
        .valid_o  (if_id_valid_o)
    );

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (ifid_load && !branch_taken_i) begin
                stat_fetched_q <= stat_fetched_q + 32'd1;
            end
            if (freeze_i || fetch_busy_o) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_fetched_o = stat_fetched_q;
    assign stat_stall_o   = stat_stall_q;
`endif

endmodule
